floating_point_adder: RTL and testbench

FLOATING_POINT_ADDER -- requirements
Module: floating_point_adder

---
 rtl/floating_point_adder_if.sv | 17 +
 rtl/floating_point_adder.sv | 178 +++++++++++++++++
 tb/tb_floating_point_adder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/floating_point_adder_if.sv
// Operand/result bundle for floating_point_adder; the adder's ports map one-to-one
// onto these signals.
interface floating_point_inf #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
);
  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic [W-1:0] fp_a_i;
  logic [W-1:0] fp_b_i;
  logic         valid_i;
  logic [W-1:0] fp_o;
  logic         valid_o;

  modport master (output fp_a_i, fp_b_i, valid_i, input fp_o, valid_o);
  modport slave  (input fp_a_i, fp_b_i, valid_i, output fp_o, valid_o);
endinterface

// File: rtl/floating_point_adder.sv
// Pipelined IEEE-754 style adder, RNE rounding, operands registered then three compute stages.
// Define FLOATING_POINT_ADDER_SUBNORMAL_EN for gradual underflow; default flushes subnormals to zero.
module floating_point_adder #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_a_i,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_b_i,
  input  logic                            valid_i,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_o,
  output logic                            valid_o
);
  localparam int W    = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int MW   = FRAC_WIDTH + 4;          // {hidden, frac, guard, round, sticky}
  localparam int XW   = EXP_WIDTH + 2;           // exponent with headroom for carry/underflow
  localparam int LZW  = $clog2(MW + 1);
  localparam int EMAX = (1 << EXP_WIDTH) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  logic [3:0]           vld_pipe_q, vld_pipe_d;
  logic [W-1:0]         in_a_q, in_a_d, in_b_q, in_b_d;
  logic                 s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d, s1_spec_q, s1_spec_d;
  logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d;
  logic [MW-1:0]        s1_mbig_q, s1_mbig_d, s1_msm_q, s1_msm_d;
  logic [W-1:0]         s1_spec_val_q, s1_spec_val_d;
  logic                 s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d, s2_spec_q, s2_spec_d;
  logic [XW-1:0]        s2_exp_q, s2_exp_d;
  logic [MW-1:0]        s2_man_q, s2_man_d;
  logic [W-1:0]         s2_spec_val_q, s2_spec_val_d;
  logic [W-1:0]         fp_q, fp_d;

  // stage 1 locals
  logic                  sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_WIDTH-1:0]  ea, eb, ea_e, eb_e, e_sm, diff;
  logic [FRAC_WIDTH-1:0] fa, fb;
  logic [FRAC_WIDTH:0]   ma, mb, m_sm;
  logic [MW-1:0]         sm_ext;
  // stage 2/3 locals
  logic [MW:0]           sum;
  logic [LZW-1:0]        lz;
  int                    shamt;
  logic                  rnd_up, hid;
  logic [FRAC_WIDTH+1:0] mr;
  logic [FRAC_WIDTH-1:0] frac;
  logic [XW-1:0]         exr;
  logic [W-1:0]          res;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[2:0], valid_i};
    in_a_d     = fp_a_i;
    in_b_d     = fp_b_i;
  end

  // Stage 1: unpack, order by magnitude, align the smaller significand.
  always_comb begin
    {sa, ea, fa} = in_a_q;
    {sb, eb, fb} = in_b_q;
    a_nan = (&ea) & (|fa);
    b_nan = (&eb) & (|fb);
    a_inf = (&ea) & ~(|fa);
    b_inf = (&eb) & ~(|fb);
`ifdef FLOATING_POINT_ADDER_SUBNORMAL_EN
    ma   = {|ea, fa};
    mb   = {|eb, fb};
    ea_e = ea | {{(EXP_WIDTH-1){1'b0}}, ~|ea};
    eb_e = eb | {{(EXP_WIDTH-1){1'b0}}, ~|eb};
`else
    ma   = (|ea) ? {1'b1, fa} : '0;
    mb   = (|eb) ? {1'b1, fb} : '0;
    ea_e = ea;
    eb_e = eb;
`endif
    swap      = {eb_e, mb} > {ea_e, ma};
    s1_sign_d = swap ? sb : sa;
    s1_sub_d  = sa ^ sb;
    s1_exp_d  = swap ? eb_e : ea_e;
    s1_mbig_d = {(swap ? mb : ma), 3'b000};
    e_sm      = swap ? ea_e : eb_e;
    m_sm      = swap ? ma : mb;
    diff      = s1_exp_d - e_sm;
    sm_ext    = {m_sm, 3'b000};
    if (int'(diff) >= FRAC_WIDTH + 3) begin
      s1_msm_d = {{(MW-1){1'b0}}, |m_sm};
    end else begin
      s1_msm_d    = sm_ext >> diff;
      s1_msm_d[0] = s1_msm_d[0] | (|(sm_ext & ~({MW{1'b1}} << diff)));
    end
    s1_spec_d = a_nan | b_nan | a_inf | b_inf;
    if (a_nan | b_nan | (a_inf & b_inf & s1_sub_d)) s1_spec_val_d = QNAN;
    else if (a_inf) s1_spec_val_d = {sa, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    else            s1_spec_val_d = {sb, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
  end

  // Stage 2: add/subtract, then normalize on carry or cancellation.
  always_comb begin
    sum = s1_sub_q ? ({1'b0, s1_mbig_q} - {1'b0, s1_msm_q})
                   : ({1'b0, s1_mbig_q} + {1'b0, s1_msm_q});
    lz = LZW'(MW);
    for (int i = 0; i < MW; i++) if (sum[i]) lz = LZW'(MW - 1 - i);
`ifdef FLOATING_POINT_ADDER_SUBNORMAL_EN
    // never normalize below exponent 1; what is left is a subnormal
    shamt = (int'(lz) > int'(s1_exp_q) - 1) ? int'(s1_exp_q) - 1 : int'(lz);
`else
    shamt = int'(lz);
`endif
    s2_sign_d     = s1_sign_q;
    s2_zero_d     = 1'b0;
    s2_spec_d     = s1_spec_q;
    s2_spec_val_d = s1_spec_val_q;
    if (sum[MW]) begin
      s2_man_d = {sum[MW:2], sum[1] | sum[0]};
      s2_exp_d = XW'(s1_exp_q) + XW'(1);
    end else begin
      s2_man_d = sum[MW-1:0] << shamt;
      s2_exp_d = XW'(s1_exp_q) - XW'(shamt);
    end
    if (~|sum) begin
      s2_zero_d = 1'b1;
      s2_sign_d = s1_sign_q & ~s1_sub_q;   // x + (-x) is +0, (-0)+(-0) stays -0
    end
`ifndef FLOATING_POINT_ADDER_SUBNORMAL_EN
    else if (s2_exp_d[XW-1] || s2_exp_d == '0) s2_zero_d = 1'b1;
`endif
  end

  // Stage 3: round to nearest even, renormalize, pack.
  always_comb begin
    rnd_up = s2_man_q[2] & (s2_man_q[3] | s2_man_q[1] | s2_man_q[0]);
    mr     = {1'b0, s2_man_q[MW-1:3]} + {{(FRAC_WIDTH+1){1'b0}}, rnd_up};
    if (mr[FRAC_WIDTH+1]) begin
      frac = mr[FRAC_WIDTH:1];
      hid  = 1'b1;
      exr  = s2_exp_q + XW'(1);
    end else begin
      frac = mr[FRAC_WIDTH-1:0];
      hid  = mr[FRAC_WIDTH];
      exr  = s2_exp_q;
    end
    res = {s2_sign_q, (hid ? exr[EXP_WIDTH-1:0] : {EXP_WIDTH{1'b0}}), frac};
    if (s2_spec_q)              res = s2_spec_val_q;
    else if (s2_zero_q)         res = {s2_sign_q, {(W-1){1'b0}}};
    else if (exr >= XW'(EMAX))  res = {s2_sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    fp_d = vld_pipe_q[2] ? res : fp_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      fp_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      fp_q       <= fp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    in_a_q        <= in_a_d;
    in_b_q        <= in_b_d;
    s1_sign_q     <= s1_sign_d;
    s1_sub_q      <= s1_sub_d;
    s1_exp_q      <= s1_exp_d;
    s1_mbig_q     <= s1_mbig_d;
    s1_msm_q      <= s1_msm_d;
    s1_spec_q     <= s1_spec_d;
    s1_spec_val_q <= s1_spec_val_d;
    s2_sign_q     <= s2_sign_d;
    s2_zero_q     <= s2_zero_d;
    s2_exp_q      <= s2_exp_d;
    s2_man_q      <= s2_man_d;
    s2_spec_q     <= s2_spec_d;
    s2_spec_val_q <= s2_spec_val_d;
  end

  assign fp_o    = fp_q;
  assign valid_o = vld_pipe_q[3];
endmodule

// File: tb/tb_floating_point_adder.sv
// Directed and back-to-back checks of floating_point_adder in binary32 format.
module tb_floating_point_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  logic [31:0] ra [10];
  logic [31:0] rb [10];
  logic [31:0] rexp [10];

  always #5 clk = ~clk;

  floating_point_inf #(.EXP_WIDTH(8), .FRAC_WIDTH(23)) bus ();

  floating_point_adder #(.EXP_WIDTH(8), .FRAC_WIDTH(23)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .fp_a_i (bus.fp_a_i),
    .fp_b_i (bus.fp_b_i),
    .valid_i(bus.valid_i),
    .fp_o   (bus.fp_o),
    .valid_o(bus.valid_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // One isolated operation: valid_o must rise exactly on the fourth negedge after driving.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp);
    @(negedge clk);
    bus.fp_a_i  = a;
    bus.fp_b_i  = b;
    bus.valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      check({tag, " valid_o"}, {31'b0, bus.valid_o}, (k == 4) ? 32'd1 : 32'd0);
    end
    check(tag, bus.fp_o, exp);
  endtask

  // Exact integer sum followed by a single RNE rounding; normal inputs only.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint va, vb, s, mag, q, rem, half;
    int     ea, eb, emin, p, k, e;
    logic   sgn;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    emin = (ea < eb) ? ea : eb;
    va   = {40'd0, 1'b1, a[22:0]};
    vb   = {40'd0, 1'b1, b[22:0]};
    va   = va << (ea - emin);
    vb   = vb << (eb - emin);
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    s = va + vb;
    if (s == 0) return 32'h0;
    sgn = (s < 0);
    mag = sgn ? -s : s;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (p > 23) begin
      k    = p - 23;
      q    = mag >> k;
      rem  = mag & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        k = k + 1;
      end
      e = emin + k;
    end else begin
      q = mag << (23 - p);
      e = emin - (23 - p);
    end
    return {sgn, e[7:0], q[22:0]};
  endfunction

  initial begin
    logic [31:0] ea_r, eb_r, fa_r, fb_r, sa_r, sb_r;
    bus.fp_a_i  = '0;
    bus.fp_b_i  = '0;
    bus.valid_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset valid_o", {31'b0, bus.valid_o}, 32'd0);
    check("reset fp_o", bus.fp_o, 32'd0);
    rst = 1'b0;

    op("1+1",          32'h3F800000, 32'h3F800000, 32'h40000000);
    op("1-1",          32'h3F800000, 32'hBF800000, 32'h00000000);
    op("-0+-0",        32'h80000000, 32'h80000000, 32'h80000000);
    op("+0+-0",        32'h00000000, 32'h80000000, 32'h00000000);
    op("tie even",     32'h3F800000, 32'h33800000, 32'h3F800000);
    op("tie odd",      32'h3F800001, 32'h33800000, 32'h3F800002);
    op("2-3",          32'h40000000, 32'hC0400000, 32'hBF800000);
    op("1.5+1.5",      32'h3FC00000, 32'h3FC00000, 32'h40400000);
    op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    op("inf-inf",      32'h7F800000, 32'hFF800000, 32'h7FC00000);
    op("nan in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    op("inf+1",        32'h7F800000, 32'h3F800000, 32'h7F800000);
    op("-inf+-inf",    32'hFF800000, 32'hFF800000, 32'hFF800000);
    op("tiny sub+1",   32'h00000001, 32'h3F800000, 32'h3F800000);
`ifdef FLOATING_POINT_ADDER_SUBNORMAL_EN
    op("sub+sub",      32'h00400000, 32'h00400000, 32'h00800000);
    op("underflow",    32'h00800001, 32'h80800000, 32'h00000001);
`else
    op("sub+sub",      32'h00400000, 32'h00400000, 32'h00000000);
    op("underflow",    32'h00800001, 32'h80800000, 32'h00000000);
`endif

    // back-to-back random normal operands, exponents kept close so the model stays exact
    for (int i = 0; i < 10; i++) begin
      ea_r = $urandom_range(110, 140);
      eb_r = $urandom_range(110, 140);
      fa_r = $urandom;
      fb_r = $urandom;
      sa_r = $urandom_range(0, 1);
      sb_r = $urandom_range(0, 1);
      ra[i]   = {sa_r[0], ea_r[7:0], fa_r[22:0]};
      rb[i]   = {sb_r[0], eb_r[7:0], fb_r[22:0]};
      rexp[i] = ref_add(ra[i], rb[i]);
    end
    for (int j = 0; j <= 14; j++) begin
      @(negedge clk);
      if (j >= 4 && j <= 13) begin
        check($sformatf("stream %0d valid_o", j - 4), {31'b0, bus.valid_o}, 32'd1);
        check($sformatf("stream %0d", j - 4), bus.fp_o, rexp[j-4]);
      end
      if (j == 14) check("stream end valid_o", {31'b0, bus.valid_o}, 32'd0);
      if (j < 10) begin
        bus.fp_a_i  = ra[j];
        bus.fp_b_i  = rb[j];
        bus.valid_i = 1'b1;
      end else begin
        bus.valid_i = 1'b0;
      end
    end

    // two ops in flight, then reset: they must vanish
    @(negedge clk);
    bus.fp_a_i  = 32'h3F800000;
    bus.fp_b_i  = 32'h3F800000;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.fp_a_i  = 32'h40000000;
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("in reset valid_o", {31'b0, bus.valid_o}, 32'd0);
      check("in reset fp_o", bus.fp_o, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("flushed valid_o", {31'b0, bus.valid_o}, 32'd0);
    end

    op("after reset", 32'h3F800000, 32'h3F800000, 32'h40000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
